// File: rtl/compare_pkg.sv
// Shared definitions for the comparator core and its result buffer:
// the result codes the core emits and the buffer FSM state encoding.
package compare_pkg;

    // Result codes produced on the comparator's c output.
    localparam logic [15:0] CODE_GT      = 16'd1;
    localparam logic [15:0] CODE_EQ      = 16'd2;
    localparam logic [15:0] CODE_EQ_NEST = 16'd3;

    // RUN moves words normally; FLUSH drains the FIFO one entry per cycle.
    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } crb_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with level tracking. The head entry is read
// combinationally so that a word written in one cycle is visible at the
// head in the next cycle. 'drop' discards the head without a consumer,
// which the owner uses to drain the FIFO during a flush.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     drop,
    output logic [$clog2(DEPTH):0]   level,
    output logic [WIDTH-1:0]         head_data
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;
    logic             advance;

    // Pop and drop both retire the head entry; the owner never asserts both.
    assign advance   = pop | drop;
    assign level     = level_q;
    assign head_data = mem_q[rd_ptr_q];

    // Occupancy: a simultaneous push and retire leaves it unchanged.
    always_comb begin
        level_d = level_q;
        if (push && !advance) begin
            level_d = level_q + LW'(1);
        end else if (!push && advance) begin
            level_d = level_q - LW'(1);
        end
    end

    // Storage write; no reset so the array maps onto plain memory.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap modulo DEPTH by natural overflow; full/empty come from level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (advance) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/compare_result_buffer.sv
// Result buffer behind the comparator core: queues result words in a FIFO,
// hands them on with valid/ready, classifies each accepted word into
// saturating counters and supports a flush that drains all stored entries.
module compare_result_buffer
    import compare_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] level,
    output logic [CNT_W-1:0]       cnt_gt,
    output logic [CNT_W-1:0]       cnt_eq,
    output logic [CNT_W-1:0]       cnt_data,
    output logic                   cnt_sat
);

    localparam int LW = $clog2(DEPTH) + 1;

    crb_state_e              state_q;
    logic                    running;
    logic [LW-1:0]           fifo_level;
    logic [WIDTH-1:0]        head_data;
    logic                    push_hs;
    logic                    pop_hs;
    logic                    drop;
    logic [2:0]              hit;
    logic [2:0][CNT_W-1:0]   cnt_q;
    logic [2:0][CNT_W-1:0]   cnt_d;
    logic                    cnt_sat_q;
    logic                    cnt_sat_d;

    assign running   = (state_q == RUN);
    assign out_valid = running && (fifo_level != '0);
    assign pop_hs    = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign in_ready  = running && ((fifo_level < LW'(DEPTH)) || pop_hs);
    assign push_hs   = in_valid && in_ready;
    assign drop      = !running && (fifo_level != '0);
    assign out_data  = out_valid ? head_data : '0;
    assign level     = fifo_level;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_hs),
        .push_data (in_data),
        .pop       (pop_hs),
        .drop      (drop),
        .level     (fifo_level),
        .head_data (head_data)
    );

    // Control FSM: a flush in RUN lets that cycle's handshakes finish first;
    // FLUSH ends once the last entry is being discarded (or none is left).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (flush) begin
                        state_q <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (fifo_level <= LW'(1)) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    // Classify the incoming word: index 0 = a>b, 1 = equal/nested, 2 = data.
    always_comb begin
        hit    = '0;
        hit[0] = (in_data == WIDTH'(CODE_GT));
        hit[1] = (in_data == WIDTH'(CODE_EQ)) || (in_data == WIDTH'(CODE_EQ_NEST));
        hit[2] = !(hit[0] || hit[1]);
    end

    // Counter next state: increment on accept, hold at all-ones; sticky flag.
    always_comb begin
        cnt_d     = cnt_q;
        cnt_sat_d = cnt_sat_q;
        for (int i = 0; i < 3; i++) begin
            if (push_hs && hit[i] && (cnt_q[i] != '1)) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            if (cnt_d[i] == '1) begin
                cnt_sat_d = 1'b1;
            end
        end
    end

    // Counter registers; only reset clears them, flush leaves them alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            cnt_sat_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            cnt_sat_q <= cnt_sat_d;
        end
    end

    assign cnt_gt   = cnt_q[0];
    assign cnt_eq   = cnt_q[1];
    assign cnt_data = cnt_q[2];
    assign cnt_sat  = cnt_sat_q;

endmodule
